unlock_arbiter: RTL and testbench

- Controller that sequences and shares access to a power-on lock register between N requesters.
- Each requester presents an unlock key. A round-robin arbiter picks one, and a constant-time comparator checks the key against a fixed secret.
- A match produces a single unlock pulse to the lock register. Repeated mismatches escalate to a lockout that rejects all further attempts.

---
 rtl/unlock_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/unlock_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_unlock_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unlock_pkg.sv
// Shared types and constants for the unlock arbiter: FSM state encoding,
// failure counter width and the default lockout duration.
package unlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT      = 3'd1,
    ST_CMP        = 3'd2,
    ST_RESP       = 3'd3,
    ST_LOCKED_OUT = 3'd4
  } state_e;

  localparam int LOCKOUT_CYC_DEF = 1024;
  localparam int FAIL_CNT_W      = 4;

  // Failure counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (v == '1) ? v : v + FAIL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer;
// the pointer moves past the winner when update is pulsed.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             update,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] pos;
  int               sum;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = 0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= N) sum = sum - N;
      pos = IDX_W'(sum);
      if (!grant_vld && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = pos;
        grant_vld  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update && grant_vld) begin
      ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/unlock_arbiter.sv
// Shares a lock register between N_REQ requesters: round-robin grant, fixed-time
// sliced key compare, unlock pulse on match, lockout after MAX_FAILS misses.
// Define UNLOCK_ARB_LOCKOUT_TIMEOUT_EN to make the lockout expire after LOCKOUT_CYC cycles.
// Handshake: req is held high until ack; ack is a one-cycle pulse with ok valid alongside it.
module unlock_arbiter
  import unlock_pkg::*;
#(
  parameter int               N_REQ       = 4,
  parameter int               KEY_W       = 64,
  parameter int               CMP_W       = 16,
  parameter logic [KEY_W-1:0] UNLOCK_KEY  = 64'hA5A5_0F0F_3C3C_9669,
  parameter int               MAX_FAILS   = 3,
  parameter int               LOCKOUT_CYC = LOCKOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*KEY_W-1:0] key_in,
  output logic [N_REQ-1:0]       ack,
  output logic                   ok,
  input  logic                   locked,
  output logic                   unlock_pulse,
  output logic                   lockout,
  output logic [FAIL_CNT_W-1:0]  fail_cnt,
  output logic [2:0]             state_dbg
);

  localparam int NSLC  = KEY_W / CMP_W;
  localparam int SLC_W = (NSLC > 1) ? $clog2(NSLC) : 1;
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [SLC_W-1:0]      SLC_LAST   = SLC_W'(NSLC - 1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_LIMIT = FAIL_CNT_W'(MAX_FAILS);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [KEY_W-1:0]        key_q, key_d;
  logic [SLC_W-1:0]        slc_q, slc_d;
  logic                    flag_q, flag_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic                    ok_q, ok_d;
  logic                    pulse_q, pulse_d;
  logic                    lockout_q, lockout_d;
  logic [FAIL_CNT_W-1:0]   fail_q, fail_d;

  logic [N_REQ-1:0]        arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_vld;
  logic                    arb_update;
  logic [KEY_W-1:0]        key_sel;
  logic [CMP_W-1:0]        key_slice, secret_slice;
  logic                    slice_diff;

`ifdef UNLOCK_ARB_LOCKOUT_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCKOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCKOUT_CYC - 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_lockout_cyc;
  assign unused_lockout_cyc = ^LOCKOUT_CYC;
`endif

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .update    (arb_update),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // AND-OR mux driven straight from the one-hot grant.
  always_comb begin
    key_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      key_sel = key_sel | (KEY_W'(key_in >> (i * KEY_W)) & {KEY_W{arb_grant[i]}});
    end
  end

  // One slice per cycle, every slice always visited, so timing never depends on the key.
  assign key_slice    = CMP_W'(key_q >> (int'(slc_q) * CMP_W));
  assign secret_slice = CMP_W'(UNLOCK_KEY >> (int'(slc_q) * CMP_W));
  assign slice_diff   = |(key_slice ^ secret_slice);

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    key_d      = key_q;
    slc_d      = slc_q;
    flag_d     = flag_q;
    fail_d     = fail_q;
    lockout_d  = lockout_q;
    ack_d      = '0;
    ok_d       = 1'b0;
    pulse_d    = 1'b0;
    arb_update = 1'b0;
`ifdef UNLOCK_ARB_LOCKOUT_TIMEOUT_EN
    to_d       = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req && !lockout_q) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (arb_vld) begin
          arb_update = 1'b1;
          gnt_idx_d  = arb_idx;
          key_d      = key_sel;
          slc_d      = '0;
          flag_d     = 1'b0;
          state_d    = ST_CMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMP: begin
        flag_d = flag_q | slice_diff;
        if (slc_q == SLC_LAST) begin
          state_d           = ST_RESP;
          ack_d[gnt_idx_q]  = 1'b1;
          ok_d              = ~flag_d;
          pulse_d           = ~flag_d & locked;
          fail_d            = flag_d ? sat_inc(fail_q) : '0;
        end else begin
          slc_d = slc_q + SLC_W'(1);
        end
      end
      ST_RESP: begin
        if (fail_q >= FAIL_LIMIT) begin
          state_d   = ST_LOCKED_OUT;
          lockout_d = 1'b1;
`ifdef UNLOCK_ARB_LOCKOUT_TIMEOUT_EN
          to_d      = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED_OUT: begin
        // Every pending requester is refused at once; a held req sees one ack per two cycles.
        ack_d = req & ~ack_q;
`ifdef UNLOCK_ARB_LOCKOUT_TIMEOUT_EN
        if (to_q == TO_LAST) begin
          state_d   = ST_IDLE;
          lockout_d = 1'b0;
          fail_d    = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= '0;
      key_q     <= '0;
      slc_q     <= '0;
      flag_q    <= 1'b0;
      ack_q     <= '0;
      ok_q      <= 1'b0;
      pulse_q   <= 1'b0;
      lockout_q <= 1'b0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      key_q     <= key_d;
      slc_q     <= slc_d;
      flag_q    <= flag_d;
      ack_q     <= ack_d;
      ok_q      <= ok_d;
      pulse_q   <= pulse_d;
      lockout_q <= lockout_d;
      fail_q    <= fail_d;
    end
  end

`ifdef UNLOCK_ARB_LOCKOUT_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`endif

  assign ack          = ack_q;
  assign ok           = ok_q;
  assign unlock_pulse = pulse_q;
  assign lockout      = lockout_q;
  assign fail_cnt     = fail_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_unlock_arbiter.sv
// Bench for unlock_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (round-robin pointer, failure count, lockout flag).
module tb_unlock_arbiter;

  localparam int N           = 4;
  localparam int KEY_W       = 64;
  localparam int CMP_W       = 16;
  localparam int MAX_FAILS   = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam logic [KEY_W-1:0] SECRET = 64'hA5A5_0F0F_3C3C_9669;
  localparam int LAT  = 2 + KEY_W / CMP_W;
  // Next grant after an ack passes through one IDLE cycle first.
  localparam int TURN = LAT + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N*KEY_W-1:0] key_in;
  logic [N-1:0]       ack;
  logic               ok;
  logic               locked;
  logic               unlock_pulse;
  logic               lockout;
  logic [3:0]         fail_cnt;
  logic [2:0]         state_dbg;

  int checks = 0;
  int errors = 0;
  int m_ptr, m_fail;
  bit m_lockout;

  typedef struct {
    int         lat;
    logic [N-1:0] ack;
    logic       ok;
    logic       pulse;
    logic [3:0] fail;
  } res_t;

  unlock_arbiter #(
    .N_REQ(N), .KEY_W(KEY_W), .CMP_W(CMP_W), .UNLOCK_KEY(SECRET),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .key_in(key_in), .ack(ack), .ok(ok),
    .locked(locked), .unlock_pulse(unlock_pulse), .lockout(lockout),
    .fail_cnt(fail_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; locked = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0; m_fail = 0; m_lockout = 0;
  endtask

  task automatic set_key(input int i, input logic [KEY_W-1:0] k);
    key_in[i*KEY_W +: KEY_W] = k;
  endtask

  function automatic logic [KEY_W-1:0] bad_key();
    logic [KEY_W-1:0] m;
    m = 64'd1 << $urandom_range(0, KEY_W - 1);
    return SECRET ^ m;
  endfunction

  task automatic wait_ack(input int budget, output res_t r);
    r.lat = -1; r.ack = '0; r.ok = 1'b0; r.pulse = 1'b0; r.fail = '0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack !== '0) begin
        r.lat = c; r.ack = ack; r.ok = ok; r.pulse = unlock_pulse; r.fail = fail_cnt;
        break;
      end
    end
  endtask

  // Transaction model: winner is the first pending requester at or after the pointer.
  task automatic model_step(input logic [N-1:0] pend, input int lat, output res_t e, output int win);
    logic good;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (win < 0 && pend[j]) win = j;
    end
    good = (key_in[win*KEY_W +: KEY_W] == SECRET);
    e.lat = lat; e.ack = '0; e.ack[win] = 1'b1; e.ok = good; e.pulse = good && locked;
    if (good) m_fail = 0;
    else if (m_fail < 15) m_fail++;
    e.fail = 4'(m_fail);
    m_ptr = (win + 1) % N;
    if (m_fail >= MAX_FAILS) m_lockout = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; key_in = '0; locked = 1'b0;
    @(negedge clk);
    checks++; if (ack !== '0)         begin errors++; $display("FAIL reset ack: got %b exp 0", ack); end
    checks++; if (ok !== 1'b0)        begin errors++; $display("FAIL reset ok: got %b exp 0", ok); end
    checks++; if (unlock_pulse !== 1'b0) begin errors++; $display("FAIL reset pulse: got %b exp 0", unlock_pulse); end
    checks++; if (lockout !== 1'b0)   begin errors++; $display("FAIL reset lockout: got %b exp 0", lockout); end
    checks++; if (fail_cnt !== 4'd0)  begin errors++; $display("FAIL reset fail_cnt: got %0d exp 0", fail_cnt); end
    reset = 1'b0;
    m_ptr = 0; m_fail = 0; m_lockout = 0;
  endtask

  task automatic test_match();
    res_t o, e; int w;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      locked = (pass == 0);
      set_key(0, SECRET);
      req = 4'b0001;
      model_step(req, LAT, e, w);
      wait_ack(20, o);
      req = '0;
      checks++; if (o.lat !== e.lat)     begin errors++; $display("FAIL match%0d latency: got %0d exp %0d", pass, o.lat, e.lat); end
      checks++; if (o.ack !== e.ack)     begin errors++; $display("FAIL match%0d ack: got %b exp %b", pass, o.ack, e.ack); end
      checks++; if (o.ok !== e.ok)       begin errors++; $display("FAIL match%0d ok: got %b exp %b", pass, o.ok, e.ok); end
      checks++; if (o.pulse !== e.pulse) begin errors++; $display("FAIL match%0d pulse: got %b exp %b", pass, o.pulse, e.pulse); end
      checks++; if (o.fail !== e.fail)   begin errors++; $display("FAIL match%0d fail_cnt: got %0d exp %0d", pass, o.fail, e.fail); end
      @(negedge clk);
      checks++; if (ack !== '0 || unlock_pulse !== 1'b0) begin
        errors++; $display("FAIL match%0d pulse width: got ack=%b pulse=%b exp 0", pass, ack, unlock_pulse);
      end
    end
  endtask

  task automatic test_wrong_key();
    res_t o, e; int w;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      // LSB-slice flip first, then MSB-slice flip: both must take the full compare time.
      set_key(pass * 2, (pass == 0) ? (SECRET ^ 64'd1) : (SECRET ^ {1'b1, 63'd0}));
      req = '0; req[pass*2] = 1'b1;
      model_step(req, LAT, e, w);
      wait_ack(20, o);
      req = '0;
      checks++; if (o.lat !== e.lat)     begin errors++; $display("FAIL wrong%0d latency: got %0d exp %0d", pass, o.lat, e.lat); end
      checks++; if (o.ack !== e.ack)     begin errors++; $display("FAIL wrong%0d ack: got %b exp %b", pass, o.ack, e.ack); end
      checks++; if (o.ok !== e.ok)       begin errors++; $display("FAIL wrong%0d ok: got %b exp %b", pass, o.ok, e.ok); end
      checks++; if (o.pulse !== e.pulse) begin errors++; $display("FAIL wrong%0d pulse: got %b exp %b", pass, o.pulse, e.pulse); end
      checks++; if (o.fail !== e.fail)   begin errors++; $display("FAIL wrong%0d fail_cnt: got %0d exp %0d", pass, o.fail, e.fail); end
      @(negedge clk);
    end
  endtask

  task automatic test_lockout();
    res_t o, e; int w;
    apply_reset();
    for (int n = 0; n < MAX_FAILS; n++) begin
      set_key(1, bad_key());
      req = 4'b0010;
      model_step(req, LAT, e, w);
      wait_ack(20, o);
      req = '0;
      checks++; if (o.ack !== e.ack || o.ok !== e.ok || o.fail !== e.fail) begin
        errors++; $display("FAIL lockout attempt%0d: got ack=%b ok=%b fail=%0d exp ack=%b ok=%b fail=%0d",
                           n, o.ack, o.ok, o.fail, e.ack, e.ok, e.fail);
      end
      @(negedge clk);
    end
    checks++; if (lockout !== 1'(m_lockout)) begin errors++; $display("FAIL lockout flag: got %b exp %b", lockout, m_lockout); end
    checks++; if (fail_cnt !== 4'(m_fail))   begin errors++; $display("FAIL lockout fail_cnt: got %0d exp %0d", fail_cnt, m_fail); end
    set_key(1, SECRET);
    req = 4'b0010;
    wait_ack(20, o);
    req = '0;
    checks++; if (o.lat !== 1)         begin errors++; $display("FAIL refused latency: got %0d exp 1", o.lat); end
    checks++; if (o.ack !== 4'b0010)   begin errors++; $display("FAIL refused ack: got %b exp 0010", o.ack); end
    checks++; if (o.ok !== 1'b0)       begin errors++; $display("FAIL refused ok: got %b exp 0", o.ok); end
    checks++; if (o.pulse !== 1'b0)    begin errors++; $display("FAIL refused pulse: got %b exp 0", o.pulse); end
    checks++; if (o.fail !== 4'(m_fail)) begin errors++; $display("FAIL refused fail_cnt: got %0d exp %0d", o.fail, m_fail); end
  endtask

  task automatic test_arbitration();
    res_t o, e; int w;
    apply_reset();
    for (int i = 0; i < N; i++) set_key(i, SECRET);
    req = '1;
    for (int n = 0; n < 5; n++) begin
      model_step(req, (n == 0) ? LAT : TURN, e, w);
      wait_ack(20, o);
      checks++; if (o.ack !== e.ack) begin errors++; $display("FAIL arb%0d ack: got %b exp %b", n, o.ack, e.ack); end
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL arb%0d spacing: got %0d exp %0d", n, o.lat, e.lat); end
      checks++; if (o.ok !== e.ok || o.pulse !== e.pulse) begin
        errors++; $display("FAIL arb%0d result: got ok=%b pulse=%b exp ok=%b pulse=%b", n, o.ok, o.pulse, e.ok, e.pulse);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    res_t o, e; int w; bit first;
    apply_reset();
    for (int b = 0; b < 12; b++) begin
      req = 4'($urandom_range(1, 15));
      first = 1;
      while (req != '0) begin
        for (int i = 0; i < N; i++) begin
          if (m_fail >= MAX_FAILS - 1 || $urandom_range(0, 1) == 0) set_key(i, SECRET);
          else set_key(i, bad_key());
        end
        locked = 1'($urandom_range(0, 1));
        model_step(req, first ? LAT : TURN, e, w);
        wait_ack(30, o);
        req[w] = 1'b0;
        first = 0;
        checks++; if (o.lat !== e.lat)     begin errors++; $display("FAIL rand%0d latency: got %0d exp %0d", b, o.lat, e.lat); end
        checks++; if (o.ack !== e.ack)     begin errors++; $display("FAIL rand%0d ack: got %b exp %b", b, o.ack, e.ack); end
        checks++; if (o.ok !== e.ok)       begin errors++; $display("FAIL rand%0d ok: got %b exp %b", b, o.ok, e.ok); end
        checks++; if (o.pulse !== e.pulse) begin errors++; $display("FAIL rand%0d pulse: got %b exp %b", b, o.pulse, e.pulse); end
        checks++; if (o.fail !== e.fail)   begin errors++; $display("FAIL rand%0d fail_cnt: got %0d exp %0d", b, o.fail, e.fail); end
        checks++; if (lockout !== 1'b0)    begin errors++; $display("FAIL rand%0d lockout: got %b exp 0", b, lockout); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    res_t o, e; int w; int seen;
    apply_reset();
    set_key(1, bad_key());
    req = 4'b0010;
    model_step(req, LAT, e, w);
    wait_ack(20, o);
    req = '0;
    checks++; if (o.fail !== e.fail) begin errors++; $display("FAIL rmid setup fail_cnt: got %0d exp %0d", o.fail, e.fail); end
    @(negedge clk);
    set_key(2, SECRET);
    req = 4'b0100;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (ack !== '0 || ok !== 1'b0 || unlock_pulse !== 1'b0 || lockout !== 1'b0) begin
      errors++; $display("FAIL rmid outputs: got ack=%b ok=%b pulse=%b lockout=%b exp all 0", ack, ok, unlock_pulse, lockout);
    end
    checks++; if (fail_cnt !== 4'd0) begin errors++; $display("FAIL rmid fail_cnt: got %0d exp 0", fail_cnt); end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0; m_fail = 0; m_lockout = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack !== '0 || unlock_pulse !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid stray ack: got %0d cycles exp 0", seen); end
    for (int i = 0; i < N; i++) set_key(i, SECRET);
    req = '1;
    model_step(req, LAT, e, w);
    wait_ack(20, o);
    req = '0;
    checks++; if (o.ack !== e.ack) begin errors++; $display("FAIL rmid restart ack: got %b exp %b", o.ack, e.ack); end
    checks++; if (o.lat !== e.lat || o.pulse !== e.pulse) begin
      errors++; $display("FAIL rmid restart: got lat=%0d pulse=%b exp lat=%0d pulse=%b", o.lat, o.pulse, e.lat, e.pulse);
    end
    @(negedge clk);
  endtask

`ifdef UNLOCK_ARB_LOCKOUT_TIMEOUT_EN
  task automatic test_timeout();
    res_t o, e; int w; int cnt;
    apply_reset();
    for (int n = 0; n < MAX_FAILS; n++) begin
      set_key(3, bad_key());
      req = 4'b1000;
      model_step(req, LAT, e, w);
      wait_ack(20, o);
      req = '0;
    end
    @(negedge clk);
    checks++; if (lockout !== 1'b1) begin errors++; $display("FAIL timeout entry lockout: got %b exp 1", lockout); end
    cnt = 0;
    while (lockout === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt !== LOCKOUT_CYC) begin errors++; $display("FAIL timeout duration: got %0d exp %0d", cnt, LOCKOUT_CYC); end
    checks++; if (fail_cnt !== 4'd0)   begin errors++; $display("FAIL timeout fail_cnt: got %0d exp 0", fail_cnt); end
    m_fail = 0; m_lockout = 0;
    set_key(3, SECRET);
    locked = 1'b1;
    req = 4'b1000;
    model_step(req, LAT, e, w);
    wait_ack(20, o);
    req = '0;
    checks++; if (o.lat !== e.lat || o.ack !== e.ack) begin
      errors++; $display("FAIL timeout unlock: got lat=%0d ack=%b exp lat=%0d ack=%b", o.lat, o.ack, e.lat, e.ack);
    end
    checks++; if (o.ok !== 1'b1 || o.pulse !== 1'b1) begin
      errors++; $display("FAIL timeout unlock result: got ok=%b pulse=%b exp 1 1", o.ok, o.pulse);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_wrong_key();
    test_lockout();
    test_arbitration();
    test_random();
    test_reset_mid();
`ifdef UNLOCK_ARB_LOCKOUT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
